// File: rtl/mlsd_pkg.sv
// Shared helpers for the MLSD sequence estimator: symbol mapping,
// signed saturation and cursor geometry.
package mlsd_pkg;

  // Map an nbit symbol code to its signed PAM level: 2*b - (2**nbit - 1).
  function automatic int sym_map(input int b, input int bits_per_sym);
    return 2 * b - ((1 << bits_per_sym) - 1);
  endfunction

  // Clamp a signed value into the range of a signed field of the given width.
  function automatic longint sat_signed(input longint value, input int width);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -(longint'(1) <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Flat symbol index of lane 0 inside the buffer word holding the cursor.
  function automatic int cursor_pos_offset(input int center_buffer, input int num_channels);
    return center_buffer * num_channels;
  endfunction

endpackage

// File: rtl/mlsd_tap_bank.sv
// Double-buffered channel taps: writes go to the shadow bank and a commit
// copies the whole shadow bank into the active bank on a single edge.
module mlsd_tap_bank #(
  parameter int estDepth    = 3,
  parameter int tapBitwidth = 8,
  parameter int addrWidth   = 2
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            wr_en,
  input  logic [addrWidth-1:0]            wr_addr,
  input  logic [tapBitwidth-1:0]          wr_data,
  input  logic                            tap_upd,
  output logic [estDepth*tapBitwidth-1:0] active_taps
);

  logic [estDepth-1:0][tapBitwidth-1:0] shadow_q, shadow_d;
  logic [estDepth-1:0][tapBitwidth-1:0] active_q, active_d;

  // Commit reads the shadow bank before this cycle's write lands in it,
  // so a write coincident with a commit only affects the shadow bank.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (tap_upd) active_d = shadow_q;
    if (wr_en && (int'(wr_addr) < estDepth)) shadow_d[wr_addr] = wr_data;
  end

  // Bank registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_taps = active_q;

endmodule

// File: rtl/mlsd_seq_estimator.sv
// Generates, for every lane and every candidate cursor symbol, the expected
// code sequence seen by the MLSD comparator. Two register stages: products,
// then saturated sums.
//
// Valid protocol: in_valid marks flat_bits as meaningful for one cycle; there
// is no ready/backpressure, every accepted input produces exactly one
// out_valid cycle two edges later, and est_seq holds between outputs.
//
// est_seq layout: element (c, gi, k) sits at bit offset
// ((c*numChannels + gi)*seqLength + k)*codeBitwidth.
module mlsd_seq_estimator import mlsd_pkg::*; #(
  parameter int seqLength    = 4,
  parameter int codeBitwidth = 10,
  parameter int tapBitwidth  = 8,
  parameter int estDepth     = 3,
  parameter int numChannels  = 16,
  parameter int bufferDepth  = 3,
  parameter int centerBuffer = 1,
  parameter int nbit         = 1,
  parameter int cbit         = 1,
  parameter int outShift     = 0
) (
  input  logic                                                   clk,
  input  logic                                                   rstb,
  input  logic                                                   in_valid,
  input  logic [numChannels*bufferDepth*nbit-1:0]                flat_bits,
  input  logic                                                   wr_en,
  input  logic [$clog2(estDepth)-1:0]                            wr_addr,
  input  logic signed [tapBitwidth-1:0]                          wr_data,
  input  logic                                                   tap_upd,
  output logic                                                   out_valid,
  output logic [(2**nbit)*numChannels*seqLength*codeBitwidth-1:0] est_seq
);

  localparam int NUM_CAND    = 2 ** nbit;
  localparam int ADDR_W      = $clog2(estDepth);
  localparam int PROD_W      = tapBitwidth + nbit + 1;
  localparam int SUM_W       = PROD_W + $clog2(estDepth);
  localparam int NUM_EST     = NUM_CAND * numChannels * seqLength;
  localparam int NUM_PROD    = NUM_EST * estDepth;
  localparam int CURSOR_BASE = cursor_pos_offset(centerBuffer, numChannels);
  localparam int MIN_IDX     = CURSOR_BASE + cbit - (estDepth - 1);

  // Past-bit lookups must stay inside the decided-bit buffer.
  if (MIN_IDX < 0) begin : g_bad_geometry
    $error("mlsd_seq_estimator: cursor geometry reaches below flat_bits index 0");
  end

  logic [estDepth*tapBitwidth-1:0] active_taps;
  logic [NUM_PROD*PROD_W-1:0]      prod_d, prod_q;
  logic                            valid1_q;
  logic [NUM_EST*codeBitwidth-1:0] est_d, est_q;
  logic                            out_valid_q;

  // Words after the cursor word and lanes past the cursor never feed a term.
  logic unused_flat_bits;
  assign unused_flat_bits = ^flat_bits;

  mlsd_tap_bank #(
    .estDepth   (estDepth),
    .tapBitwidth(tapBitwidth),
    .addrWidth  (ADDR_W)
  ) u_tap_bank (
    .clk        (clk),
    .rstb       (rstb),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .tap_upd    (tap_upd),
    .active_taps(active_taps)
  );

  // Stage 1 products: each tap meets the candidate symbol at the cursor,
  // a decided symbol before it, or nothing after it (future bits unknown).
  always_comb begin
    int p;
    int pos;
    int tap_v;
    int sym_v;
    p      = 0;
    pos    = 0;
    tap_v  = 0;
    sym_v  = 0;
    prod_d = '0;
    for (int c = 0; c < NUM_CAND; c++) begin
      for (int gi = 0; gi < numChannels; gi++) begin
        for (int k = 0; k < seqLength; k++) begin
          for (int j = 0; j < estDepth; j++) begin
            p     = ((c * numChannels + gi) * seqLength + k) * estDepth + j;
            pos   = cbit + k - j;
            tap_v = int'($signed(active_taps[j*tapBitwidth +: tapBitwidth]));
            if (pos > 0) begin
              sym_v = 0;
            end else if (pos == 0) begin
              sym_v = sym_map(c, nbit);
            end else begin
              sym_v = sym_map(int'(flat_bits[(CURSOR_BASE + gi + pos)*nbit +: nbit]), nbit);
            end
            prod_d[p*PROD_W +: PROD_W] = PROD_W'(tap_v * sym_v);
          end
        end
      end
    end
  end

  // Stage 1 register: taps are captured together with the data, so one
  // estimate never mixes two banks.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      valid1_q <= 1'b0;
      prod_q   <= '0;
    end else begin
      valid1_q <= in_valid;
      if (in_valid) prod_q <= prod_d;
    end
  end

  // Stage 2 sums: full-precision add, arithmetic shift, then saturation.
  always_comb begin
    logic signed [SUM_W-1:0] acc;
    longint                  shifted;
    int                      e;
    acc     = '0;
    shifted = 0;
    e       = 0;
    est_d   = est_q;
    if (valid1_q) begin
      for (int c = 0; c < NUM_CAND; c++) begin
        for (int gi = 0; gi < numChannels; gi++) begin
          for (int k = 0; k < seqLength; k++) begin
            e   = (c * numChannels + gi) * seqLength + k;
            acc = '0;
            for (int j = 0; j < estDepth; j++) begin
              acc = acc + SUM_W'($signed(prod_q[(e*estDepth + j)*PROD_W +: PROD_W]));
            end
            shifted = longint'(acc) >>> outShift;
            est_d[e*codeBitwidth +: codeBitwidth] =
              codeBitwidth'(sat_signed(shifted, codeBitwidth));
          end
        end
      end
    end
  end

  // Stage 2 register: outputs hold when no new estimate arrives.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      out_valid_q <= 1'b0;
      est_q       <= '0;
    end else begin
      out_valid_q <= valid1_q;
      est_q       <= est_d;
    end
  end

  assign out_valid = out_valid_q;
  assign est_seq   = est_q;

endmodule

// File: tb/tb_mlsd_seq_estimator.sv
// Directed bench for mlsd_seq_estimator: default instance plus an 8-bit
// output instance for saturation, driven by the same inputs.
module tb_mlsd_seq_estimator;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rstb;
  logic              in_valid;
  logic [47:0]       flat_bits;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic signed [7:0] wr_data;
  logic              tap_upd;
  logic              out_valid_a, out_valid_b;
  logic [1279:0]     est_a;
  logic [1023:0]     est_b;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Hand-computed expectations, uniform across lanes: [code][candidate][sample].
  // 0: all zero; 1: taps {10,5,2} bits 1; 2: taps {10,5,2} bits 0;
  // 3: taps {20,0,9} bits 1.
  int exp_tab[4][2][4] = '{
    '{'{0, 0, 0, 0},  '{0, 0, 0, 0}},
    '{'{-3, -2, 0, 0}, '{7, 2, 0, 0}},
    '{'{-7, -2, 0, 0}, '{3, 2, 0, 0}},
    '{'{9, -9, 0, 0},  '{9, 9, 0, 0}}
  };
  logic [1:0] exp_q[$];

  mlsd_seq_estimator u_dut_a (
    .clk      (clk),
    .rstb     (rstb),
    .in_valid (in_valid),
    .flat_bits(flat_bits),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .tap_upd  (tap_upd),
    .out_valid(out_valid_a),
    .est_seq  (est_a)
  );

  mlsd_seq_estimator #(.codeBitwidth(8)) u_dut_b (
    .clk      (clk),
    .rstb     (rstb),
    .in_valid (in_valid),
    .flat_bits(flat_bits),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .tap_upd  (tap_upd),
    .out_valid(out_valid_b),
    .est_seq  (est_b)
  );

  // ---------------- helpers ----------------
  function automatic int est_val_a(input int c, input int gi, input int k);
    int idx;
    idx = ((c * 16 + gi) * 4 + k) * 10;
    return int'($signed(est_a[idx +: 10]));
  endfunction

  function automatic int est_val_b(input int c, input int gi, input int k);
    int idx;
    idx = ((c * 16 + gi) * 4 + k) * 8;
    return int'($signed(est_b[idx +: 8]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_lanes(input string tag, input int code);
    for (int gi = 0; gi < 16; gi++)
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 4; k++)
          check_int($sformatf("%s lane%0d c%0d k%0d", tag, gi, c, k),
                    est_val_a(c, gi, k), exp_tab[code][c][k]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_tap(input logic [1:0] a, input logic signed [7:0] v);
    wr_en = 1'b1; wr_addr = a; wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic commit();
    tap_upd = 1'b1;
    tick();
    tap_upd = 1'b0;
  endtask

  task automatic pulse_input();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // One cycle of stimulus; any output seen after the edge is matched
  // against the oldest queued expectation.
  task automatic step(input string tag, input logic in_v, input logic we,
                      input logic [1:0] wa, input logic signed [7:0] wd,
                      input logic upd, input logic [1:0] code);
    logic [1:0] got_code;
    in_valid = in_v; wr_en = we; wr_addr = wa; wr_data = wd; tap_upd = upd;
    if (in_v) exp_q.push_back(code);
    tick();
    in_valid = 1'b0; wr_en = 1'b0; tap_upd = 1'b0;
    if (out_valid_a) begin
      check_int({tag, " output expected"}, exp_q.size() > 0 ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        got_code = exp_q.pop_front();
        check_lanes(tag, int'(got_code));
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstb = 1'b0; in_valid = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; tap_upd = 1'b0; flat_bits = '0;
    tick(); tick();

    // Reset state
    check_bit("reset out_valid", out_valid_a, 1'b0);
    check_lanes("reset est", 0);

    // Loaded taps are cleared by a one-cycle reset
    rstb = 1'b1;
    write_tap(2'd0, 8'sd10); write_tap(2'd1, 8'sd5); write_tap(2'd2, 8'sd2);
    commit();
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    check_bit("reset2 out_valid", out_valid_a, 1'b0);
    flat_bits = '1;
    step("zero taps", 1'b1, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) step("zero taps", 1'b0, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd0);
    check_int("zero taps drained", exp_q.size(), 0);

    // Taps {10,5,2}, out-of-range write ignored, past bits 1, latency 2
    write_tap(2'd0, 8'sd10); write_tap(2'd1, 8'sd5); write_tap(2'd2, 8'sd2);
    write_tap(2'd3, 8'sd99);
    commit();
    flat_bits = '1;
    pulse_input();
    check_bit("lat edge1 out_valid", out_valid_a, 1'b0);
    tick();
    check_bit("lat edge2 out_valid", out_valid_a, 1'b1);
    check_lanes("bits1", 1);
    tick();
    check_bit("single pulse out_valid", out_valid_a, 1'b0);
    check_lanes("hold", 1);

    // Past bits 0
    flat_bits = '0;
    pulse_input();
    tick();
    check_bit("bits0 out_valid", out_valid_a, 1'b1);
    check_lanes("bits0", 2);
    tick();

    // Eight back-to-back inputs give eight consecutive outputs
    for (int i = 0; i < 10; i++) begin
      step("b2b", i < 8, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd2);
      check_bit($sformatf("b2b out_valid %0d", i), out_valid_a, (i >= 1 && i <= 8));
    end
    check_int("b2b drained", exp_q.size(), 0);

    // Per-lane past bits: lane gi uses flat_bits[15+gi]
    flat_bits = 48'hA5C3_96F0_1E2D;
    pulse_input();
    tick();
    for (int gi = 0; gi < 16; gi++) begin
      int s;
      s = flat_bits[15 + gi] ? 2 : -2;
      check_int($sformatf("mixed lane%0d c1 k0", gi), est_val_a(1, gi, 0), 5 + s);
      check_int($sformatf("mixed lane%0d c0 k0", gi), est_val_a(0, gi, 0), -5 + s);
      check_int($sformatf("mixed lane%0d c1 k1", gi), est_val_a(1, gi, 1), 2);
      check_int($sformatf("mixed lane%0d c0 k1", gi), est_val_a(0, gi, 1), -2);
    end
    tick();

    // Saturation: taps {0,127,127}
    write_tap(2'd0, 8'sd0); write_tap(2'd1, 8'sd127); write_tap(2'd2, 8'sd127);
    commit();
    flat_bits = '1;
    pulse_input();
    tick();
    check_bit("sat out_valid_b", out_valid_b, 1'b1);
    for (int gi = 0; gi < 16; gi++) begin
      check_int($sformatf("sat8 hi lane%0d c1 k0", gi), est_val_b(1, gi, 0), 127);
      check_int($sformatf("sat10 lane%0d c1 k0", gi), est_val_a(1, gi, 0), 254);
      check_int($sformatf("sat8 lane%0d c0 k0", gi), est_val_b(0, gi, 0), 0);
      check_int($sformatf("sat8 lane%0d c1 k1", gi), est_val_b(1, gi, 1), 127);
      check_int($sformatf("sat8 lane%0d c0 k1", gi), est_val_b(0, gi, 1), -127);
    end
    tick();
    flat_bits = '0;
    pulse_input();
    tick();
    for (int gi = 0; gi < 16; gi++) begin
      check_int($sformatf("sat8 lo lane%0d c0 k0", gi), est_val_b(0, gi, 0), -128);
      check_int($sformatf("sat10 lo lane%0d c0 k0", gi), est_val_a(0, gi, 0), -254);
      check_int($sformatf("sat8 lo lane%0d c1 k0", gi), est_val_b(1, gi, 0), 0);
    end
    tick();

    // Commit during streaming: outputs switch banks cleanly
    write_tap(2'd0, 8'sd10); write_tap(2'd1, 8'sd5); write_tap(2'd2, 8'sd2);
    commit();
    flat_bits = '1;
    step("stream", 1'b1, 1'b0, 2'd0, 8'sd0,  1'b0, 2'd1);
    step("stream", 1'b1, 1'b1, 2'd0, 8'sd20, 1'b0, 2'd1);
    step("stream", 1'b1, 1'b1, 2'd1, 8'sd0,  1'b0, 2'd1);
    step("stream", 1'b1, 1'b1, 2'd2, 8'sd0,  1'b0, 2'd1);
    step("stream upd", 1'b1, 1'b1, 2'd2, 8'sd9, 1'b1, 2'd1);
    step("stream new", 1'b1, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd0);
    step("stream new", 1'b1, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) step("stream drain", 1'b0, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd0);
    check_int("stream drained", exp_q.size(), 0);

    // The write made alongside the commit stayed in shadow: taps {20,0,9}
    step("late write", 1'b0, 1'b0, 2'd0, 8'sd0, 1'b1, 2'd0);
    step("late write", 1'b1, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd3);
    for (int i = 0; i < 3; i++) step("late write", 1'b0, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd0);
    check_int("late write drained", exp_q.size(), 0);

    // Reset one cycle after an input discards it and clears the taps
    pulse_input();
    rstb = 1'b0;
    tick();
    check_bit("midrst edge out_valid", out_valid_a, 1'b0);
    rstb = 1'b1;
    tick();
    check_bit("midrst +1 out_valid", out_valid_a, 1'b0);
    tick();
    check_bit("midrst +2 out_valid", out_valid_a, 1'b0);
    step("post reset", 1'b1, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) step("post reset", 1'b0, 1'b0, 2'd0, 8'sd0, 1'b0, 2'd0);
    check_int("post reset drained", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlsd_seq_estimator.md
Name: mlsd_seq_estimator

Overview:
- Pipelined generator of the per-candidate expected code sequences used by the MLSD decision comparator.
- Inputs: previously decided bits and the channel pulse-response taps.
- Output: est_seq[candidate][channel][sample], registered, with a valid strobe.
- Taps are double-buffered: written over a simple write port, then committed atomically so that no estimate ever mixes old and new taps.

Parameters:
seqLength, 4, samples per estimated sequence
codeBitwidth, 10, signed width of each estimate
tapBitwidth, 8, signed width of each channel tap
estDepth, 3, number of channel taps (tap 0 = precursor-free main term)
numChannels, 16, parallel lanes
bufferDepth, 3, depth in words of the decided-bit buffer
centerBuffer, 1, buffer word holding the cursor bits
nbit, 1, bits per symbol (PAM-2**nbit)
cbit, 1, offset of the first sequence sample after the cursor
outShift, 0, arithmetic right shift applied before saturation

Ports:
clk  input  1  clock
rstb  input  1  synchronous active-low reset
in_valid  input  1  flat_bits valid this cycle
flat_bits  input  [nbit-1:0] x numChannels*bufferDepth  decided symbols, oldest at index 0
wr_en  input  1  shadow tap write strobe
wr_addr  input  $clog2(estDepth)  shadow tap index
wr_data  input  signed tapBitwidth  shadow tap value
tap_upd  input  1  copy shadow bank to active bank
out_valid  output  1  est_seq valid
est_seq  output  signed codeBitwidth x [2**nbit][numChannels][seqLength]  expected sequences

Behaviour:
- Clocking and reset:
  - Single clock clk; synchronous active-low reset rstb; all state updates on the rising edge.
  - While rstb=0: shadow and active taps cleared to 0, pipeline valids cleared, out_valid=0, all est_seq=0.
  - Reset mid-operation discards in-flight data; the first out_valid after reset requires a new in_valid.
- Symbol map: sym(b) = 2*b - (2**nbit - 1). For nbit=1: bit 1 -> +1, bit 0 -> -1.
- Sample geometry, for lane gi, candidate c, sample k:
  - s = cbit + k.
  - For each tap j: pos = s - j, relative to the lane cursor.
- Tap term selection:
  - pos > 0: term is 0 (future bits unknown).
  - pos == 0: term is tap[j]*sym(c).
  - pos < 0: term is tap[j]*sym(flat_bits[centerBuffer*numChannels + gi + pos]).
  - Elaboration-time assertion: the minimum index centerBuffer*numChannels + cbit - (estDepth-1) is >= 0.
- Arithmetic:
  - Full-precision signed sum over j: width tapBitwidth + nbit + 1 + $clog2(estDepth).
  - Then arithmetic right shift by outShift.
  - Then saturate to [-2**(codeBitwidth-1), 2**(codeBitwidth-1)-1].
- Pipeline: fixed 2-cycle latency.
  - Stage 1: register the products, selected from flat_bits and the active taps.
  - Stage 2: register the saturated sums and the valid.
  - An in_valid at edge N yields out_valid=1 after edge N+2.
  - No backpressure; back-to-back in_valid gives back-to-back outputs.
  - When out_valid=0, est_seq holds its last value.
- Tap banks:
  - wr_en writes wr_data to shadow[wr_addr].
  - An out-of-range wr_addr is ignored.
  - tap_upd copies shadow to active in one edge.
- Simultaneous events:
  - wr_en with tap_upd: active takes the pre-write shadow; the write lands in shadow.
  - in_valid with tap_upd: that input uses the old active taps; the new taps apply from the next input.
  - Taps are sampled with the data in stage 1, so every output uses a single bank.

Decomposition:
- Shared package mlsd_pkg:
  - sym_map function.
  - Saturation function sat_signed(value, width).
  - Localparam helper for cursor_pos_offset.
- One sub-module, mlsd_tap_bank: shadow/active registers, write port and commit. The estimator instantiates it and holds the two-stage arithmetic pipeline.

Test Plan:
1. Reset with taps loaded then rstb=0 for 1 cycle -> out_valid=0, all est_seq=0, active taps read back 0 (the next estimate with any bits is all 0).
2. Write taps {10,5,2}, tap_upd, flat_bits all 1, one in_valid -> after 2 cycles out_valid=1 for 1 cycle. Every lane: est[1]=[7,2,0,0] and est[0]=[-3,-2,0,0].
3. Same taps with past bits all 0 -> est[1]=[3,2,0,0] and est[0]=[-7,-2,0,0]. Then 8 back-to-back in_valid -> 8 consecutive out_valid.
4. With codeBitwidth=8, taps {0,127,127}, past bits 1 -> est[1][*][0] saturates to 127. Past bits 0 with candidate 0 -> est[0][*][0]=-128.
5. Write shadow taps {20,0,0} while in_valid streams, then tap_upd together with in_valid:
   - Up to and including the tap_upd cycle, outputs use the old taps {10,5,2}.
   - The next input gives est[1]=[0,0,0,0], because tap0 never reaches s>=cbit.
   - With wr_en in the tap_upd cycle, the active bank holds the pre-write value.
6. Assert rstb=0 one cycle after in_valid -> no out_valid appears; estimates from the next in_valid are computed with zero taps (all 0).
